// File: rtl/mac_pkg.sv
// Shared types and default sizing for the multiply-accumulate consumer.
// Build option: define MAC_ACC_SATURATE_EN to clamp instead of wrap on overflow.
package mac_pkg;

    localparam int DEF_PROD_W  = 16;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_N_TERMS = 4;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/mac_accumulator_rise_edge_det.sv
// Registers the multiplier done level and flags its rising edge, so a done
// held high for many cycles contributes exactly one product.
module rise_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q_rise
);

    logic done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= d;
        end
    end

    assign q_rise = d & ~done_q;

endmodule

// File: rtl/mac_accumulator.sv
// Sums N_TERMS multiplier products into a wide accumulator and hands the result
// out over valid/ready. Define MAC_ACC_SATURATE_EN to clamp on overflow (default wraps).
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W  = DEF_PROD_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int N_TERMS = DEF_N_TERMS,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_done,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc,
    output logic              out_valid,
    output logic              overflow,
    output logic              busy,
    output logic [CNT_W-1:0]  terms
);

    logic             counted;
    state_t           state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] terms_reg;
    logic             overflow_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    rise_edge_det u_done_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (prod_done),
        .q_rise (counted)
    );

    // One extra bit on the adder exposes the carry out of the accumulator.
    logic [ACC_W:0]   sum_wide;
    logic             carry;
    logic [ACC_W-1:0] add_result;
    logic [CNT_W-1:0] terms_inc;
    logic             last_term;

    assign sum_wide  = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign carry     = sum_wide[ACC_W];
    assign terms_inc = terms_reg + CNT_W'(1);
    assign last_term = (terms_inc == CNT_W'(N_TERMS));

`ifdef MAC_ACC_SATURATE_EN
    // Once clamped, any further non-zero product carries again, so it stays clamped.
    assign add_result = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign add_result = sum_wide[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            acc_reg       <= '0;
            terms_reg     <= '0;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        acc_reg      <= '0;
                        terms_reg    <= '0;
                        overflow_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    // A restart takes priority and drops a coincident product.
                    if (start) begin
                        acc_reg      <= '0;
                        terms_reg    <= '0;
                        overflow_reg <= 1'b0;
                    end else if (counted) begin
                        acc_reg      <= add_result;
                        terms_reg    <= terms_inc;
                        overflow_reg <= overflow_reg | carry;
                        if (last_term) begin
                            busy_reg      <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

    assign acc       = acc_reg;
    assign terms     = terms_reg;
    assign overflow  = overflow_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Downstream consumer of the 8-bit multiplier in the ALU datapath. It captures each 16-bit product when the multiplier signals `done`, and sums a fixed number of products into a wide accumulator. It then presents the sum through a valid/ready output handshake. Together with the multiplier it forms a multiply-accumulate (dot-product) path.

## Interface
Parameters:
- `PROD_W`, 16: product width; matches multiplier output.
- `ACC_W`, 24: accumulator width; must be ≥ `PROD_W`.
- `N_TERMS`, 4: products summed per accumulation; range 1..2^`CNT_W`-1.
- `CNT_W`, 8: term-counter width.

Ports:
- `clk` in 1: rising-edge clock, shared with multiplier.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; clears and begins a new accumulation.
- `prod` in `PROD_W`: product from multiplier `op`.
- `prod_done` in 1: multiplier `done`; may be held high for many cycles.
- `out_ready` in 1: consumer accepts result.
- `acc` out `ACC_W`: accumulated sum.
- `out_valid` out 1: `acc` is final.
- `overflow` out 1: sticky; an add exceeded `ACC_W` during this accumulation.
- `busy` out 1: high in ACCUM.
- `terms` out `CNT_W`: products accumulated so far.

## Operation
- Edge detect: `done_q` registers `prod_done` every cycle in all states. A product counts only when `prod_done & ~done_q`. A `done` already high at start is ignored until it falls and rises again.
- States:
  - IDLE: `busy`=0, `out_valid`=0, `acc` holds its last value. `start` clears `acc`, `terms` and `overflow`, then moves to ACCUM.
  - ACCUM: on each counted edge, `acc` ← `acc` + zero-extended `prod` (unsigned) and `terms` increments. When `terms` reaches `N_TERMS`, move to HOLD.
  - HOLD: `out_valid`=1. `acc`, `terms` and `overflow` are frozen. When `out_valid & out_ready`, move to IDLE.
- Arithmetic: a carry out of bit `ACC_W`-1 sets `overflow` (sticky until next `start`). Result handling depends on the `SATURATE_EN` macro (see Configuration).
- Simultaneous events:
  - `start` and a counted edge in the same cycle, in IDLE or ACCUM: `start` wins. The accumulator is cleared and the edge is dropped.
  - `start` in HOLD: ignored.
  - Counted edges in IDLE or HOLD: ignored; `done_q` still updates.
- Reset mid-operation: all state is discarded immediately. No partial result is retained.

## Timing
- Reset values: state IDLE; `acc`=0, `out_valid`=0, `overflow`=0, `busy`=0, `terms`=0, `done_q`=0.
- Accumulation latency: `acc` and `terms` update on the first rising `clk` where `prod_done`=1 and `done_q`=0.
- `out_valid` rises on the same edge as the final add.
- `busy` rises on the edge after `start`.
- Handshake:
  - `out_valid` and `acc` stay stable until a cycle with `out_ready`=1.
  - `out_valid` falls on that edge.
  - `out_ready` while `out_valid`=0 has no effect.
- Fastest back-to-back: `start` is accepted in the cycle after the handshake completes.

## Configuration
- `MAC_ACC_SATURATE_EN` defined: on overflow, `acc` clamps to all-ones and stays clamped for the remaining terms. `overflow` sets.
- Undefined: `acc` wraps modulo 2^`ACC_W`. `overflow` sets identically.

## Structure
- Package `mac_pkg` holds:
  - the state enum (`S_IDLE`, `S_ACCUM`, `S_HOLD`);
  - default `PROD_W`/`ACC_W`/`N_TERMS`/`CNT_W` constants.
- Sub-module `rise_edge_det` (clk, rst_n, d, q_rise) contains the `done_q` register and the rising-edge logic. Everything else stays in the top.

## Test plan
- Reset mid-ACCUM, with two terms already summed: `acc`=0, `terms`=0, state IDLE immediately; no `out_valid` afterwards.
- `start`, then four `done` pulses with `prod`=0x4286 (131×130): `acc`=0x010A18, `terms`=4, `out_valid`=1, `overflow`=0.
- `prod_done` held high across `start`, then high for 10 cycles twice more: the pre-start high level is not counted, and each later pulse counts once (`terms`=2).
- `out_ready`=0 for 5 cycles in HOLD, with `start` and `prod_done` toggling: `acc`/`out_valid` unchanged. Then `out_ready`=1: `out_valid`=0 on the next edge, state IDLE.
- `start` coinciding with a `done` rising edge: `acc`=0, `terms`=0 afterwards.
- Overflow, with `ACC_W`=17, `N_TERMS`=3, `prod`=0xFE01 (255×255) each pulse:
  - wrap build: `acc`=0x0FA03, `overflow`=1;
  - `MAC_ACC_SATURATE_EN` build: `acc`=0x1FFFF, `overflow`=1.
